// File: rtl/display_source_arbiter.sv
// Round-robin owner selection for one shared seven-segment display, with a minimum hold time per owner.
// All outputs are registered, so a request is granted on the next edge. Data follows Values[Owner] one cycle late.
module display_source_arbiter #(
  parameter int N          = 4,
  parameter int Size       = 4,
  parameter int HoldCycles = 50_000_000
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [N-1:0]         Request,
  input  logic [N*Size-1:0]    Values,
  output logic [N-1:0]         Grant,
  output logic [$clog2(N)-1:0] Owner,
  output logic [Size-1:0]      Data,
  output logic                 Blank,
  output logic                 Switch
);

  localparam int OW = $clog2(N);
  localparam int CW = $clog2(HoldCycles + 1);
  localparam logic [CW-1:0] LastCnt = CW'(HoldCycles - 1);
  localparam logic [CW-1:0] SatCnt  = CW'(HoldCycles);

  typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [OW-1:0]   pick;
  logic            found;
  logic            own_req;
  logic            others;
  logic            hold_done;
  logic            do_switch;

  // The scan starts just after the current owner, so the owner itself comes last.
  always_comb begin
    pick  = Owner;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && Request[(int'(Owner) + k) % N]) begin
        pick  = OW'((int'(Owner) + k) % N);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    own_req   = Request[Owner];
    others    = |(Request & ~Grant);
    hold_done = (state == OPEN) || ((state == HOLD) && (cnt == LastCnt));
    if (state == IDLE || !own_req)
      do_switch = |Request;
    else
      do_switch = hold_done && others;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      Grant  <= '0;
      Owner  <= OW'(N - 1);
      Data   <= '0;
      Blank  <= 1'b1;
      Switch <= 1'b0;
    end else begin
      Switch <= do_switch;
      if (do_switch) begin
        state <= HOLD;
        cnt   <= '0;
        Owner <= pick;
        Grant <= N'(1) << pick;
        Data  <= Values[int'(pick)*Size +: Size];
        Blank <= 1'b0;
      end else if (state != IDLE) begin
        if (!own_req) begin
          // Released with nobody waiting: blank the display but keep Owner for the next scan.
          state <= IDLE;
          cnt   <= '0;
          Grant <= '0;
          Blank <= 1'b1;
        end else begin
          Data <= Values[int'(Owner)*Size +: Size];
          if (hold_done)
            state <= OPEN;
          if (cnt != SatCnt)
            cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_display_source_arbiter.sv
// Bench for display_source_arbiter: two instances (hold 4 and hold 2) driven by the same
// directed and random stimulus, each compared every cycle against a behavioural model.
module tb_display_source_arbiter;

  logic        Clock;
  logic        Reset;
  logic [3:0]  Request;
  logic [15:0] Values;

  logic [3:0] g4, d4, g2, d2;
  logic [1:0] o4, o2;
  logic       b4, s4, b2, s2;

  int errors = 0;
  int checks = 0;
  int sw_cnt;

  display_source_arbiter #(.N(4), .Size(4), .HoldCycles(4)) dut4 (
    .Clock(Clock), .Reset(Reset), .Request(Request), .Values(Values),
    .Grant(g4), .Owner(o4), .Data(d4), .Blank(b4), .Switch(s4)
  );

  display_source_arbiter #(.N(4), .Size(4), .HoldCycles(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .Request(Request), .Values(Values),
    .Grant(g2), .Owner(o2), .Data(d2), .Blank(b2), .Switch(s2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Model: who owns the display, how many cycles it has been shown, what is shown.
  typedef struct packed {
    logic        busy;
    logic [1:0]  owner;
    logic [31:0] held;
    logic [3:0]  data;
    logic        sw;
  } mstate_t;

  mstate_t m4, m2;

  function automatic mstate_t mreset();
    mstate_t r;
    r.busy  = 1'b0;
    r.owner = 2'd3;
    r.held  = 0;
    r.data  = 4'd0;
    r.sw    = 1'b0;
    return r;
  endfunction

  function automatic int mpick(input int owner, input logic [3:0] req);
    for (int k = 1; k <= 4; k++)
      if (req[(owner + k) % 4]) return (owner + k) % 4;
    return owner;
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic [3:0] req,
                                   input logic [15:0] vals, input int hold);
    mstate_t n;
    int p;
    logic own, oth;
    n    = s;
    n.sw = 1'b0;
    p    = mpick(int'(s.owner), req);
    own  = req[s.owner];
    oth  = (req & ~(4'b0001 << s.owner)) != 4'b0000;
    if (!s.busy || !own) begin
      if (req != 4'b0000) begin
        n.busy = 1'b1; n.owner = 2'(p); n.held = 0; n.data = vals[p*4 +: 4]; n.sw = 1'b1;
      end else begin
        n.busy = 1'b0;
      end
    end else begin
      n.held = (s.held < 1000) ? s.held + 1 : s.held;
      n.data = vals[int'(s.owner)*4 +: 4];
      if (int'(n.held) >= hold && oth) begin
        n.busy = 1'b1; n.owner = 2'(p); n.held = 0; n.data = vals[p*4 +: 4]; n.sw = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string tag, input mstate_t m, input logic [3:0] g,
                           input logic [1:0] o, input logic [3:0] d, input logic b, input logic s);
    chk({tag, ".grant"},  32'(g), m.busy ? (32'd1 << m.owner) : 32'd0);
    chk({tag, ".owner"},  32'(o), 32'(m.owner));
    chk({tag, ".data"},   32'(d), 32'(m.data));
    chk({tag, ".blank"},  32'(b), 32'(!m.busy));
    chk({tag, ".switch"}, 32'(s), 32'(m.sw));
  endtask

  task automatic cycle();
    @(posedge Clock);
    m4 = step(m4, Request, Values, 4);
    m2 = step(m2, Request, Values, 2);
    #1;
    check_dut("h4", m4, g4, o4, d4, b4, s4);
    check_dut("h2", m2, g2, o2, d2, b2, s2);
  endtask

  initial begin
    Reset   = 1'b1;
    Request = 4'b0000;
    Values  = 16'h0000;
    m4 = mreset();
    m2 = mreset();
    #2;
    check_dut("reset4", m4, g4, o4, d4, b4, s4);
    check_dut("reset2", m2, g2, o2, d2, b2, s2);
    @(negedge Clock);
    Reset = 1'b0;
    cycle();

    // Two requesters, hold 4: 0 wins first, then 2 after four cycles.
    Request = 4'b0101;
    Values  = 16'h0703;
    cycle();
    chk("tp1.first_grant", 32'(g4), 32'h1);
    chk("tp1.first_data",  32'(d4), 32'h3);
    chk("tp1.first_sw",    32'(s4), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("tp1.held_grant", 32'(g4), 32'h1);
    end
    cycle();
    chk("tp1.next_grant", 32'(g4), 32'h4);
    chk("tp1.next_data",  32'(d4), 32'h7);
    Request = 4'b0000;
    cycle();

    // Lone requester holds past the hold time with a single Switch pulse.
    Request = 4'b0010;
    sw_cnt  = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      sw_cnt += int'(s4);
      chk("tp2.blank", 32'(b4), 32'h0);
    end
    chk("tp2.switch_count", 32'(sw_cnt), 32'd1);

    // Owner 1 drops early while 3 waits: direct handover, no blank cycle.
    Request = 4'b0000;
    cycle();
    Request = 4'b0010;
    cycle();
    cycle();
    Values  = 16'h9000;
    Request = 4'b1000;
    cycle();
    chk("tp3.grant", 32'(g4), 32'h8);
    chk("tp3.sw",    32'(s4), 32'h1);
    chk("tp3.blank", 32'(b4), 32'h0);

    // Release with nobody waiting, then the same owner comes back.
    Request = 4'b0000;
    cycle();
    chk("tp4.grant", 32'(g4), 32'h0);
    chk("tp4.blank", 32'(b4), 32'h1);
    chk("tp4.data",  32'(d4), 32'h9);
    chk("tp4.owner", 32'(o4), 32'h3);
    Values  = 16'h5000;
    Request = 4'b1000;
    cycle();
    chk("tp4.regrant", 32'(g4), 32'h8);
    chk("tp4.redata",  32'(d4), 32'h5);

    // Everyone requesting, hold 2: 0,1,2,3,0 with two cycles each.
    Request = 4'b0000;
    cycle();
    Request = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("tp5.rr_grant",  32'(g2), 32'd1 << ((i / 2) % 4));
      chk("tp5.rr_switch", 32'(s2), 32'((i % 2) == 0));
    end

    // Random traffic with sticky request patterns.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(3) == 0) Request = 4'($urandom);
      Values = 16'($urandom);
      cycle();
    end

    // Asynchronous reset between edges while an owner is in its hold window.
    Request = 4'b0000;
    cycle();
    Request = 4'b0100;
    cycle();
    cycle();
    #3;
    Reset = 1'b1;
    #1;
    m4 = mreset();
    m2 = mreset();
    chk("tp6.async_grant", 32'(g4), 32'h0);
    chk("tp6.async_blank", 32'(b4), 32'h1);
    chk("tp6.async_data",  32'(d4), 32'h0);
    chk("tp6.async_owner", 32'(o4), 32'h3);
    chk("tp6.async_sw",    32'(s4), 32'h0);
    check_dut("tp6.async2", m2, g2, o2, d2, b2, s2);
    #2;
    Reset   = 1'b0;
    Request = 4'b1111;
    cycle();
    chk("tp6.after_grant4", 32'(g4), 32'h1);
    chk("tp6.after_grant2", 32'(g2), 32'h1);
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_source_arbiter.md
Name: display_source_arbiter

Overview:
- Shares one multiplexed seven-segment display between N independent data sources.
- Round-robin arbitration with a guaranteed minimum on-screen hold time per owner.
- Registered Data/Blank outputs feed the display driver's Data input directly; Blank gates it to an empty display.
- Sits between application producers (counters, sensors, debug values) and the Data2Segments display path.

Parameters:
N, 4, number of requesters (>= 2)
Size, 4, width of each requester value and of Data
HoldCycles, 50_000_000, minimum Clock cycles an owner keeps the display (1 s at 20 ns); must be >= 1

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Request  input  N  per-requester display request, level-sensitive
Values  input  N*Size  packed values; requester i occupies bits [i*Size +: Size]
Grant  output  N  one-hot current owner; all zero when idle
Owner  output  clog2(N)  index of current or last owner
Data  output  Size  registered value of owner, to display driver
Blank  output  1  1 = no owner, display must show empty
Switch  output  1  one-cycle pulse on every ownership change, including from IDLE

Behaviour:
- Reset (async, immediate):
  - Outputs: Grant=0, Owner=N-1, Data=0, Blank=1, Switch=0.
  - Internal: state=IDLE, hold counter=0.
  - Owner=N-1 makes requester 0 highest priority after reset.
- Round-robin pick: first i with Request[i]=1, scanning Owner+1, Owner+2, ... mod N. The current owner is scanned last.
- All outputs are registered; every transition takes effect on the next rising edge.
- IDLE:
  - Blank=1, Grant=0, Data holds its last value.
  - Any Request=1 → next edge: Grant=onehot(pick), Owner=pick, Data=Values[pick], Blank=0, Switch=1, counter=0, state=HOLD.
  - Latency from Request to Grant is 1 cycle.
- HOLD:
  - Counter increments each cycle; Data <= Values[Owner] each cycle, so Data lags Values by 1 cycle.
  - Other requests are ignored.
  - When counter == HoldCycles-1 and Request[Owner]=1 → state=OPEN.
  - HoldCycles=1 → OPEN is entered the cycle after the grant.
- OPEN:
  - Data keeps tracking Values[Owner].
  - Any other Request=1 → next edge: switch to pick, Switch=1, counter=0, state=HOLD.
  - Only the owner requesting → remain OPEN, Switch stays 0.
- Owner release (Request[Owner]=0, in HOLD or OPEN): overrides the hold time.
  - Other requests pending → switch directly to pick on the next edge with Switch=1; no IDLE cycle in between.
  - None pending → next edge: state=IDLE, Grant=0, Blank=1, Owner unchanged.
- Same-cycle events:
  - Owner drop together with new requests → treated as release with pending requests.
  - Several new requests together → round-robin order decides.
- Switch is high for exactly one cycle per change and never while Grant is unchanged.
- Width rules:
  - Counter width = clog2(HoldCycles+1); the counter saturates and does not wrap while OPEN.
  - Owner wraps N-1 → 0 in the pick scan.
- Grant is always one-hot or zero; never multi-hot.
- Reset asserted mid-HOLD: immediate return to reset values. After release, requester 0 wins the next simultaneous request.

Test Plan:
- Reset, then Request=4'b0101 with Values[0]=3, Values[2]=7, HoldCycles=4 → 1 cycle later: Grant=0001, Data=3, Switch=1 for one cycle. Grant stays 0001 for 4 cycles, then switches to 0100 with Data=7.
- Request=4'b0010 alone held long (HoldCycles=4) → Grant=0010 persists past the hold time; Switch pulses once only; Blank=0 throughout.
- Owner 1 drops Request at counter=1 while Request[3]=1 → next edge: Grant=1000, Switch=1, with no Blank cycle.
- Owner drops with no other requests → next edge: Grant=0, Blank=1, Data holds last value, Owner unchanged. A new Request[Owner] → re-granted after 1 cycle.
- All four requesting continuously, HoldCycles=2 → grant order 0,1,2,3,0; each owner held exactly 2 cycles; Switch pulses every 2 cycles.
- Reset asserted asynchronously mid-HOLD (between clock edges) → Grant=0, Blank=1, Data=0 immediately. After release with Request=1111, Grant=0001.
